// File: rtl/fifo_pkg.sv
// Shared FIFO constants and depth helper.
// Default geometry is an 8-bit wide, 8-entry FIFO.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int K_DEF      = 3;

    function automatic int depth(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Producer/consumer strobe bus of the FIFO core; master = traffic side, slave = FIFO.
// Backpressure is carried by full/empty; requests against them raise wr_err/rd_err.
interface fifo_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int K      = K_DEF
);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic [K:0]        count;
    logic              wr_err;
    logic              rd_err;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, count, wr_err, rd_err
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, count, wr_err, rd_err
    );

endinterface

// File: rtl/comp.sv
// K-bit pointer comparator: equality of A and B, plus zero detect on A.
// Purely combinational, zero latency; no flow control.
module comp #(
    parameter int K = 3
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         equal_flag,
    output logic         zero_flag
);

    assign equal_flag = (a == b);
    assign zero_flag  = (a == '0);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Synchronous FIFO core with wrap-bit pointers; 1-cycle registered read, flags follow pointers.
// Writes while full and reads while empty are dropped and flagged by one-cycle err pulses.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int K      = K_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_ptr_ctrl_if.slave       bus
);

    localparam int         DEPTH   = depth(K);
    localparam logic [K:0] PTR_ONE = {{K{1'b0}}, 1'b1};

    logic [K:0]        wptr;
    logic [K:0]        rptr;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_err_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic equal_flag;
    logic zero_flag_unused;
    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    comp #(.K(K)) u_comp (
        .a          (wptr[K-1:0]),
        .b          (rptr[K-1:0]),
        .equal_flag (equal_flag),
        .zero_flag  (zero_flag_unused)
    );

    // Equal addresses mean empty or full; the wrap bits tell which.
    assign empty  = equal_flag && (wptr[K] == rptr[K]);
    assign full   = equal_flag && (wptr[K] != rptr[K]);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_data_q <= '0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr      <= rptr + PTR_ONE;
                rd_data_q <= mem[rptr[K-1:0]];
            end
            wr_err_q <= bus.wr_en && full;
            rd_err_q <= bus.rd_en && empty;
        end
    end

    // Storage is deliberately left out of reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[K-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.count   = wptr - rptr;
    assign bus.wr_err  = wr_err_q;
    assign bus.rd_err  = rd_err_q;

endmodule
